gate_tester: RTL
================

GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, listed first among the ports.
REQ-002 Parameter SETTLE, default 2, SHALL set the number of wait cycles between driving a vector and sampling dut_y; legal range is 1..15.
REQ-003 Parameter EXP_TT, default 4'b1110 (OR2), SHALL give the expected dut_y for input vector {dut_a,dut_b}=i at bit EXP_TT[i].
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a test run; sampled only in IDLE.
REQ-007 dut_y  input  1  output of the 2-input gate under test.
REQ-008 dut_a, dut_b  output  1 each  registered stimulus to the gate under test.
REQ-009 busy  output  1  high from the first APPLY through the last SAMPLE.
REQ-010 done  output  1  single-cycle pulse at the end of a run.
REQ-011 pass  output  1  high when the completed run had no mismatches; held until the next start.
REQ-012 fail_mask  output  4  bit i set when vector i mismatched; held until the next start.
REQ-013 vec_idx  output  2  index of the vector currently applied.

Function
REQ-014 The FSM states SHALL be IDLE, APPLY, WAIT, SAMPLE and DONE.
REQ-015 IDLE with start=1 SHALL, on the next edge, enter APPLY with vec_idx=0, fail_mask=0, pass=0 and busy=1.
REQ-016 APPLY SHALL register {dut_a,dut_b}=vec_idx, load the settle counter with SETTLE, and go to WAIT.
REQ-017 WAIT SHALL decrement the counter each cycle and go to SAMPLE on the cycle the counter equals 1, so WAIT lasts exactly SETTLE cycles.
REQ-018 SAMPLE SHALL compare dut_y to EXP_TT[vec_idx] and set fail_mask[vec_idx] on mismatch; X or Z on dut_y counts as a mismatch (case-inequality).
REQ-019 After SAMPLE, the FSM SHALL go to DONE if vec_idx==3; otherwise it SHALL increment vec_idx and return to APPLY.
REQ-020 DONE SHALL last one cycle with done=1, busy=0 and pass=(fail_mask==0) including the final SAMPLE result, then return to IDLE.
REQ-021 Latency: done SHALL assert exactly 1+4*(SETTLE+2) cycles after the edge that samples start (25 cycles for SETTLE=2).
REQ-022 start asserted outside IDLE SHALL be ignored, with no queuing; start held high SHALL restart a run on the cycle after DONE.
REQ-023 dut_a and dut_b SHALL return to 0 in DONE and IDLE.
REQ-024 vec_idx SHALL wrap from 3 only through DONE and never increment past 3.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, dut_a=dut_b=0, busy=0, done=0, pass=0, fail_mask=0, vec_idx=0 and counter=0, independent of clk.
REQ-026 Reset asserted mid-run SHALL abort the run with no done pulse; the first start after release SHALL begin a fresh run.

Structure
REQ-027 Shared package gate_test_pkg SHALL hold the FSM state encoding and the truth-table constants TT_OR2=4'b1110, TT_AND2=4'b1000, TT_NOR2=4'b0001 and TT_NAND2=4'b0111.
REQ-028 The settle counter SHALL be a sub-module settle_timer (inputs load, value[3:0]; output expire) with the same clk/rst_n.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Happy path: or2 as DUT, EXP_TT=TT_OR2, SETTLE=2, start pulse -> done at cycle 25, pass=1, fail_mask=4'b0000.
- Wrong gate: and2 as DUT, EXP_TT=TT_OR2 -> pass=0, fail_mask=4'b0110.
- Stuck and floating output: dut_y tied 1 -> fail_mask=4'b0001; dut_y floating (Z) -> fail_mask=4'b1111.
- Reset mid-run: rst_n=0 during vector 2 WAIT -> all outputs 0 asynchronously, no done; restart -> normal completion.
- Start while busy: start pulsed at cycles 5 and 12 -> ignored, single done at cycle 25.
- Timing check: SETTLE=1 and SETTLE=15 -> done at cycles 13 and 69; dut_a/dut_b sequence 00,01,10,11, each held SETTLE+2 cycles.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared FSM encoding and 2-input gate truth tables for the gate tester.
// Truth-table bit i holds the expected gate output for input vector {a,b} = i.
package gate_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_NOR2  = 4'b0001;
   localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/settle_timer.sv
// Settle down-counter: load takes value, expire flags the last wait cycle (count == 1).
// Latency: expire is a decode of the registered count; no backpressure, load always wins.
module settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] value,
   output logic       expire
);

   logic [3:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 4'd0;
      end else if (load) begin
         count <= value;
      end else if (count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign expire = (count == 4'd1);

endmodule

// File: rtl/gate_tester.sv
// Exhaustive 2-input gate tester: drives vectors 0..3, waits SETTLE cycles, compares dut_y to EXP_TT.
// Latency: done pulses 1+4*(SETTLE+2) cycles after start is sampled; start outside IDLE is dropped.
module gate_tester
   import gate_test_pkg::*;
#(
   parameter int unsigned SETTLE = 2,
   parameter logic [3:0]  EXP_TT = TT_OR2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       dut_y,
   output logic       dut_a,
   output logic       dut_b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic [1:0] vec_idx
);

   localparam logic [3:0] SETTLE_V = 4'(SETTLE);

   state_t state;
   logic   expire;

   settle_timer u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (state == ST_APPLY),
      .value  (SETTLE_V),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         dut_a     <= 1'b0;
         dut_b     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_mask <= 4'd0;
         vec_idx   <= 2'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_APPLY;
                  vec_idx   <= 2'd0;
                  fail_mask <= 4'd0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            ST_APPLY: begin
               {dut_a, dut_b} <= vec_idx;
               state          <= ST_WAIT;
            end
            ST_WAIT: begin
               if (expire) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               // Case-inequality so an X or floating gate output is reported as a failure.
               if (dut_y !== EXP_TT[vec_idx]) begin
                  fail_mask[vec_idx] <= 1'b1;
               end
               if (vec_idx == 2'd3) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
               end else begin
                  vec_idx <= vec_idx + 2'd1;
                  state   <= ST_APPLY;
               end
            end
            ST_DONE: begin
               done    <= 1'b1;
               pass    <= (fail_mask == 4'd0);
               dut_a   <= 1'b0;
               dut_b   <= 1'b0;
               vec_idx <= 2'd0;
               state   <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
